// File: rtl/toggle_counter.sv
// toggle_counter: WIDTH-bit hold / toggle / up-down count / load register.
// Optional macro TOGGLE_COUNTER_WRAP_CNT_EN adds an 8-bit wrap event counter.
module toggle_counter #(
    parameter int             WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter bit             SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             up,
    input  logic [WIDTH-1:0] t_vec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
`ifdef TOGGLE_COUNTER_WRAP_CNT_EN
    ,
    output logic [7:0]       wrap_cnt
`endif
);

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_TOGGLE = 2'b01;
    localparam logic [1:0] M_COUNT  = 2'b10;
    localparam logic [1:0] M_LOAD   = 2'b11;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] tog;
    logic             at_max;
    logic             at_zero;
    logic             wrap_set;

    assign at_max   = (q == MAX_COUNT);
    assign at_zero  = (q == ZERO);
    assign q_bar    = ~q;
    assign tc       = (mode == M_COUNT) & ((up & at_max) | (~up & at_zero));
    assign wrap_set = en & tc;
    assign tog      = q ^ t_vec;

    // Next register value for the selected mode; limits handled explicitly.
    always_comb begin
        q_next = q;
        unique case (mode)
            M_HOLD: q_next = q;
            M_TOGGLE: q_next = (tog > MAX_COUNT) ? MAX_COUNT : tog;
            M_COUNT: begin
                if (up) begin
                    if (!at_max)
                        q_next = q + ONE;
                    else
                        q_next = SATURATE ? q : ZERO;
                end else begin
                    if (!at_zero)
                        q_next = q - ONE;
                    else
                        q_next = SATURATE ? q : MAX_COUNT;
                end
            end
            M_LOAD: q_next = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
        endcase
    end

    // State register and one-cycle limit-event pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= ZERO;
            wrap <= 1'b0;
        end else begin
            if (en)
                q <= q_next;
            wrap <= wrap_set;
        end
    end

`ifdef TOGGLE_COUNTER_WRAP_CNT_EN
    // Free-running count of limit events, wraps at 255.
    always_ff @(posedge clk) begin
        if (reset)
            wrap_cnt <= 8'd0;
        else if (wrap_set)
            wrap_cnt <= wrap_cnt + 8'd1;
    end
`endif

endmodule

// File: doc/toggle_counter.md
Name: toggle_counter

Overview:
Parametrised successor to the single-bit T flip-flop. Holds a WIDTH-bit register with four modes: hold, per-bit toggle, up/down count and parallel load. Count modulus is configurable, and the block can either wrap or saturate at the limits. It is used as the general-purpose counter and toggle-bank primitive in the project set, and drives dividers, timers and LED sequencers.

Parameters:
WIDTH, 4, register width in bits (1..32)
MAX_COUNT, 2**WIDTH-1, highest legal register value; count modulus is MAX_COUNT+1; must be <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at limits, 1 = stick at limits

Ports:
clk  input  1  clock, all state changes on posedge
reset  input  1  synchronous active-high reset
en  input  1  global enable; 0 = hold regardless of mode
mode  input  2  00 HOLD, 01 TOGGLE, 10 COUNT, 11 LOAD
up  input  1  COUNT direction: 1 = up, 0 = down
t_vec  input  WIDTH  per-bit toggle mask, used in TOGGLE
load_val  input  WIDTH  parallel load value, used in LOAD
q  output  WIDTH  registered state
q_bar  output  WIDTH  bitwise ~q, combinational
tc  output  1  terminal count, combinational
wrap  output  1  registered one-cycle limit-event pulse

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset on a posedge forces q=0 and wrap=0, with priority over en and mode.
- After reset, q_bar = all ones and tc = 0 unless mode=COUNT, up=0 (then tc=1 because q=0).
- Update rule: every non-reset posedge with en=0 gives q unchanged and wrap=0.
- en=1, HOLD: q unchanged.
- en=1, TOGGLE: n = q ^ t_vec. If n > MAX_COUNT, q <= MAX_COUNT (clamp); otherwise q <= n. A bit with t_vec=1 toggles and a bit with t_vec=0 holds, matching T-FF semantics per bit.
- en=1, COUNT, up=1:
  - q < MAX_COUNT: q <= q+1.
  - q == MAX_COUNT: q <= 0 if SATURATE=0, else q holds.
- en=1, COUNT, up=0:
  - q > 0: q <= q-1.
  - q == 0: q <= MAX_COUNT if SATURATE=0, else q holds.
- en=1, LOAD: q <= min(load_val, MAX_COUNT).
- Invariant: q <= MAX_COUNT at all times.
- Arithmetic: compute in WIDTH bits. The wrap and clamp logic must not rely on natural overflow, because MAX_COUNT may be less than 2**WIDTH-1.
- Latency: q reflects inputs one cycle after the sampling edge.
- tc: tc = (mode==COUNT) & ((up & q==MAX_COUNT) | (~up & q==0)). It is independent of en and SATURATE.
- wrap: wrap=1 for exactly the one cycle following an edge where en=1, mode=COUNT and tc=1. This holds in both SATURATE settings, so in saturate mode it flags a hold-at-limit. wrap is 0 in every other case.
- Direction change at a limit: tc is evaluated with the current up value. Example: up=0 at q=MAX_COUNT decrements normally, with no wrap.
- Reset mid-count: the count is lost immediately, and a wrap pending from the same edge is suppressed (wrap=0).
- Mode changes take effect on the next edge; no history is kept between modes.

Optional Feature:
Macro TOGGLE_COUNTER_WRAP_CNT_EN.
- Defined: adds an output wrap_cnt (8 bits, registered). It increments on every cycle where wrap would be asserted on the next edge, i.e. the same condition that sets wrap. It wraps 255 -> 0 and is cleared by reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=4, MAX_COUNT=9, SATURATE=0: reset, then mode=COUNT, up=1, en=1 for 12 cycles -> q = 1..9, 0, 1, 2; tc=1 while q=9; wrap=1 only in the cycle after q=9 -> 0.
- Same config, up=0 from q=0 for 3 cycles -> q = 9, 8, 7; wrap pulses once, after the 0 -> 9 step.
- SATURATE=1, MAX_COUNT=9, q loaded to 9, up=1 for 3 cycles -> q stays 9; wrap high for all 3 following cycles.
- mode=TOGGLE, q=4'b0101, t_vec=4'b0011 -> q=4'b0110; t_vec=0 -> q holds; with MAX_COUNT=9, q=0, t_vec=4'b1111 -> q clamps to 9.
- mode=LOAD, load_val=14, MAX_COUNT=9 -> q=9; en=0 with load_val=3 -> q stays 9.
- Counting at q=5 with reset asserted for 1 cycle -> q=0, wrap=0 next cycle; reset with en=1, mode=COUNT at q=MAX_COUNT -> q=0, wrap=0; with macro defined, wrap_cnt returns to 0 after reset.
